risc32_wb_arbiter: RTL and testbench

RISC32_WB_ARBITER -- requirements
Module: risc32_wb_arbiter

---
 rtl/risc32_wb_arbiter_if.sv | 54 +++++
 rtl/risc32_wb_arbiter.sv | 107 ++++++++++
 tb/tb_risc32_wb_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/risc32_wb_arbiter_if.sv
// risc32_wb_arbiter_if
//   Bundles the writeback arbiter's bus signals: two writeback requesters
//   (A = pipeline, B = multi-cycle mul/div unit), B's issue notification,
//   two scoreboard hazard query ports, the register-file write port and the
//   sticky scoreboard error flag.
//   Modports:
//     slave  - the arbiter side (takes requests, drives ready/write/busy)
//     master - the environment side (drives requests, issues and queries)
interface risc32_wb_arbiter_if;
  logic        a_valid_i;
  logic [4:0]  a_waddr_i;
  logic [31:0] a_wdata_i;
  logic        a_ready_o;

  logic        b_valid_i;
  logic [4:0]  b_waddr_i;
  logic [31:0] b_wdata_i;
  logic        b_ready_o;

  logic        b_issue_i;
  logic [4:0]  b_issue_addr_i;

  logic [4:0]  q1_addr_i;
  logic [4:0]  q2_addr_i;
  logic        q1_busy_o;
  logic        q2_busy_o;

  logic        we_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;
  logic        sb_err_o;

  modport slave (
    input  a_valid_i, a_waddr_i, a_wdata_i,
    output a_ready_o,
    input  b_valid_i, b_waddr_i, b_wdata_i,
    output b_ready_o,
    input  b_issue_i, b_issue_addr_i,
    input  q1_addr_i, q2_addr_i,
    output q1_busy_o, q2_busy_o,
    output we_o, waddr_o, wdata_o, sb_err_o
  );

  modport master (
    output a_valid_i, a_waddr_i, a_wdata_i,
    input  a_ready_o,
    output b_valid_i, b_waddr_i, b_wdata_i,
    input  b_ready_o,
    output b_issue_i, b_issue_addr_i,
    output q1_addr_i, q2_addr_i,
    input  q1_busy_o, q2_busy_o,
    input  we_o, waddr_o, wdata_o, sb_err_o
  );
endinterface

// File: rtl/risc32_wb_arbiter.sv
// risc32_wb_arbiter
//   Arbitrates the single register-file write port between the pipeline
//   writeback (A, fixed priority) and a multi-cycle unit (B). B is given a
//   forced grant after STARVE_LIMIT consecutive stalled cycles. A 31-entry
//   scoreboard tracks registers with an outstanding B result and answers two
//   hazard queries combinationally.
//   Ports:
//     clk  - clock, rising edge
//     rst  - asynchronous active-low reset
//     bus  - risc32_wb_arbiter_if.slave (requests, ready, write port,
//            scoreboard issue/query, sticky sb_err_o)
module risc32_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  risc32_wb_arbiter_if.slave        bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]  starve_cnt;
  logic        force_b;
  logic        a_ready;
  logic        b_ready;
  logic        a_xfer;
  logic        b_xfer;

  logic        we_p1;
  logic [4:0]  waddr_p1;
  logic [31:0] wdata_p1;

  // Bit 0 is never set, so queries of r0 read as not busy for free.
  logic [31:0] pending;
  logic [31:0] set_vec;
  logic [31:0] clr_vec;
  logic        sb_err;
  logic        dup_issue;

  assign force_b = (starve_cnt == LIMIT);
  assign b_ready = force_b | ~bus.a_valid_i;
  assign a_ready = ~(force_b & bus.b_valid_i);
  assign a_xfer  = bus.a_valid_i & a_ready;
  assign b_xfer  = bus.b_valid_i & b_ready;

  assign bus.a_ready_o = a_ready;
  assign bus.b_ready_o = b_ready;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (bus.b_issue_i && (bus.b_issue_addr_i != 5'd0))
      set_vec[bus.b_issue_addr_i] = 1'b1;
    if (b_xfer)
      clr_vec[bus.b_waddr_i] = 1'b1;
    set_vec[0] = 1'b0;
  end

  // A re-issue is only an error if the register is not being retired on the
  // same edge; retire-and-reissue is the normal back-to-back case.
  assign dup_issue = |(set_vec & pending & ~clr_vec);

  assign bus.q1_busy_o = pending[bus.q1_addr_i];
  assign bus.q2_busy_o = pending[bus.q2_addr_i];

  // ---- stage p1: registered write port, starvation counter, scoreboard ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
      we_p1      <= 1'b0;
      waddr_p1   <= '0;
      wdata_p1   <= '0;
      pending    <= '0;
      sb_err     <= 1'b0;
    end else begin
      if (b_xfer || !bus.b_valid_i)
        starve_cnt <= '0;
      else if (starve_cnt != LIMIT)
        starve_cnt <= starve_cnt + 4'd1;

      // Writes to r0 still complete the handshake but never reach the file.
      if (a_xfer) begin
        we_p1    <= (bus.a_waddr_i != 5'd0);
        waddr_p1 <= bus.a_waddr_i;
        wdata_p1 <= bus.a_wdata_i;
      end else if (b_xfer) begin
        we_p1    <= (bus.b_waddr_i != 5'd0);
        waddr_p1 <= bus.b_waddr_i;
        wdata_p1 <= bus.b_wdata_i;
      end else begin
        we_p1    <= 1'b0;
      end

      // Set wins over clear when both hit the same register.
      pending <= (pending & ~clr_vec) | set_vec;

      if (dup_issue)
        sb_err <= 1'b1;
    end
  end

  assign bus.we_o     = we_p1;
  assign bus.waddr_o  = waddr_p1;
  assign bus.wdata_o  = wdata_p1;
  assign bus.sb_err_o = sb_err;

endmodule

// File: tb/tb_risc32_wb_arbiter.sv
module tb_risc32_wb_arbiter;

  localparam int LIMIT = 4;

  logic clk;
  logic rst;

  risc32_wb_arbiter_if bus ();

  risc32_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];

  int          vectors;
  int          miscompares;
  int          m_cnt;
  logic [31:0] m_pend;
  logic        m_err;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          b_grants;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_pend = '0;
    m_err  = 1'b0;
    m_we   = 1'b0;
    m_addr = '0;
    m_data = '0;
    exp_q.delete();
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                       input logic iss, input logic [4:0] ia,
                       input logic [4:0] q1, input logic [4:0] q2);
    bus.a_valid_i      = av;
    bus.a_waddr_i      = aa;
    bus.a_wdata_i      = ad;
    bus.b_valid_i      = bv;
    bus.b_waddr_i      = ba;
    bus.b_wdata_i      = bd;
    bus.b_issue_i      = iss;
    bus.b_issue_addr_i = ia;
    bus.q1_addr_i      = q1;
    bus.q2_addr_i      = q2;
  endtask

  // One clock: check combinational outputs mid-cycle against the model,
  // push the expected write, advance the model at the edge, then pop and
  // compare the registered outputs just after the edge.
  task automatic cycle();
    logic        fb, ar, br, ax, bx, nerr;
    logic [31:0] nxt;
    int          ncnt;
    wr_t         e;
    @(negedge clk);
    fb = (m_cnt == LIMIT);
    ar = !(fb && bus.b_valid_i);
    br = fb || !bus.a_valid_i;
    chk("a_ready", bus.a_ready_o, ar);
    chk("b_ready", bus.b_ready_o, br);
    chk("q1_busy", bus.q1_busy_o, (bus.q1_addr_i != 0) && m_pend[bus.q1_addr_i]);
    chk("q2_busy", bus.q2_busy_o, (bus.q2_addr_i != 0) && m_pend[bus.q2_addr_i]);
    ax = bus.a_valid_i && ar;
    bx = bus.b_valid_i && br;
    if (ax) begin
      m_we = (bus.a_waddr_i != 0); m_addr = bus.a_waddr_i; m_data = bus.a_wdata_i;
    end else if (bx) begin
      m_we = (bus.b_waddr_i != 0); m_addr = bus.b_waddr_i; m_data = bus.b_wdata_i;
      b_grants++;
    end else begin
      m_we = 1'b0;
    end
    exp_q.push_back({m_we, m_addr, m_data});
    if (bx || !bus.b_valid_i) ncnt = 0;
    else if (m_cnt < LIMIT)   ncnt = m_cnt + 1;
    else                      ncnt = m_cnt;
    nxt  = m_pend;
    nerr = m_err;
    if (bx) nxt[bus.b_waddr_i] = 1'b0;
    if (bus.b_issue_i && bus.b_issue_addr_i != 0) begin
      if (m_pend[bus.b_issue_addr_i] && !(bx && bus.b_waddr_i == bus.b_issue_addr_i))
        nerr = 1'b1;
      nxt[bus.b_issue_addr_i] = 1'b1;
    end
    nxt[0] = 1'b0;
    @(posedge clk);
    m_cnt  = ncnt;
    m_pend = nxt;
    m_err  = nerr;
    #1;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("we",     bus.we_o,     e.we);
      chk("waddr",  bus.waddr_o,  e.addr);
      chk("wdata",  bus.wdata_o,  e.data);
    end
    chk("sb_err", bus.sb_err_o, m_err);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    b_grants    = 0;
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    chk("rst_we",      bus.we_o,      0);
    chk("rst_waddr",   bus.waddr_o,   0);
    chk("rst_wdata",   bus.wdata_o,   0);
    chk("rst_sb_err",  bus.sb_err_o,  0);
    chk("rst_a_ready", bus.a_ready_o, 1);
    chk("rst_b_ready", bus.b_ready_o, 1);

    // An edge while reset is held must not accept anything.
    drive(1, 5'd3, 32'hDEAD_0003, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 chk("rst_hold_we", bus.we_o, 0);
    #2 rst = 1'b1;
    cycle();                                   // first accept after release

    // A only
    drive(1, 5'd5, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();

    // Contention: A wins LIMIT cycles, then B is forced once; repeats.
    b_grants = 0;
    for (int i = 0; i < 2 * (LIMIT + 1); i++) begin
      drive(1, 5'(i + 1), 32'hA000_0000 + i, 1, 5'(20 + i), 32'hB000_0000 + i, 0, 0, 0, 0);
      cycle();
    end
    chk("b_grant_count", b_grants, 2);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();

    // Scoreboard set / clear
    drive(0, 0, 0, 0, 0, 0, 1, 5'd9, 5'd9, 5'd0);
    cycle();
    drive(0, 0, 0, 1, 5'd9, 32'h9999_0009, 0, 0, 5'd9, 5'd0);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 5'd0);
    cycle();

    // Same-edge retire and re-issue, then a genuine duplicate issue.
    drive(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 5'd9);
    cycle();
    drive(0, 0, 0, 1, 5'd7, 32'h7777_0007, 1, 5'd7, 5'd7, 5'd0);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 5'd0);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 5'd0);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd7);
    cycle();

    // Write to r0: handshake completes, no register write.
    drive(1, 5'd0, 32'hFFFF_0000, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();

    // Async reset mid-transfer with the starvation counter at its limit.
    drive(0, 0, 0, 0, 0, 0, 1, 5'd12, 5'd12, 5'd0);
    cycle();
    for (int i = 0; i < LIMIT; i++) begin
      drive(1, 5'(1 + i), 32'hC000_0000 + i, 1, 5'd25, 32'hD000_0025, 0, 0, 5'd12, 5'd0);
      cycle();
    end
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("arst_we",      bus.we_o,      0);
    chk("arst_waddr",   bus.waddr_o,   0);
    chk("arst_wdata",   bus.wdata_o,   0);
    chk("arst_q1_busy", bus.q1_busy_o, 0);
    chk("arst_a_ready", bus.a_ready_o, 1);
    chk("arst_b_ready", bus.b_ready_o, 0);
    chk("arst_sb_err",  bus.sb_err_o,  0);
    @(posedge clk);
    #1 chk("arst_hold_we", bus.we_o, 0);
    #2 rst = 1'b1;
    drive(1, 5'd6, 32'h0600_0006, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
